// File: rtl/sdes_pkg.sv
// rtl/sdes_pkg.sv - shared widths, state encoding and bit helpers for the S-DES key scheduler
//
// Bit numbering follows S-DES: position 1 is the MSB of a vector, so table
// entry p of a width-N permutation selects input index N-p.
package sdes_pkg;

    localparam int KEY_W    = 10;
    localparam int SUBKEY_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // P10 = 3 5 2 7 4 10 1 9 8 6
    function automatic logic [KEY_W-1:0] p10(input logic [KEY_W-1:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    // P8 = 6 3 7 4 8 5 10 9 (bits 1 and 2 of the input are dropped)
    function automatic logic [SUBKEY_W-1:0] p8(input logic [KEY_W-1:0] k);
        return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
    endfunction

    // Rotate a 5-bit half left; a 2-bit amount is already below 5.
    function automatic logic [4:0] rotl5(input logic [4:0] v, input logic [1:0] amt);
        logic [4:0] r;
        r = v;
        case (amt)
            2'd1:    r = {v[3:0], v[4]};
            2'd2:    r = {v[2:0], v[4:3]};
            2'd3:    r = {v[1:0], v[4:2]};
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] rotr5(input logic [4:0] v, input logic [1:0] amt);
        logic [4:0] r;
        r = v;
        case (amt)
            2'd1:    r = {v[0], v[4:1]};
            2'd2:    r = {v[1:0], v[4:2]};
            2'd3:    r = {v[2:0], v[4:3]};
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sdes_half_rot.sv
// rtl/sdes_half_rot.sv - combinational 5-bit left/right rotator for one key half
//
// Ports:
//   din       5-bit half to rotate
//   amt       rotate amount 0..3
//   dir_right 1 rotates right (decrypt walk), 0 rotates left (encrypt walk)
//   dout      rotated half
module sdes_half_rot
    import sdes_pkg::*;
(
    input  logic [4:0] din,
    input  logic [1:0] amt,
    input  logic       dir_right,
    output logic [4:0] dout
);

    always_comb begin
        dout = dir_right ? rotr5(din, amt) : rotl5(din, amt);
    end

endmodule

// File: rtl/sdes_key_sched.sv
// rtl/sdes_key_sched.sv - sequential S-DES round-key scheduler with valid/ready subkey output
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, key10, decrypt load request (IDLE only), 10-bit key, reverse-order mode
//   busy                 high outside IDLE
//   key_valid, key_ready subkey handshake
//   round_key, round_idx current subkey and its schedule index (0 when not valid)
//   done                 one-cycle pulse after the last subkey is accepted
//
// Decrypt starts from the fully rotated key and walks the schedule backwards
// with right rotations, so no subkey storage is required.
module sdes_key_sched
    import sdes_pkg::*;
#(
    parameter int                     ROUNDS      = 2,
    parameter logic [2*ROUNDS-1:0]    SHIFT_SCHED = 4'b10_01
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [KEY_W-1:0]            key10,
    input  logic                        decrypt,
    output logic                        busy,
    output logic                        key_valid,
    input  logic                        key_ready,
    output logic [SUBKEY_W-1:0]         round_key,
    output logic [$clog2(ROUNDS)-1:0]   round_idx,
    output logic                        done
);

    localparam int IDX_W = $clog2(ROUNDS);

    function automatic int calc_total_shift();
        int s;
        s = 0;
        for (int i = 0; i < ROUNDS; i++) begin
            s += int'(SHIFT_SCHED[2*i +: 2]);
        end
        return s % 5;
    endfunction

    localparam int TOTAL_SHIFT = calc_total_shift();

    // Out-of-range rounds return 0; they are only looked up on the last
    // subkey, whose handshake leaves the halves untouched anyway.
    function automatic logic [1:0] sched_amt(input int i);
        logic [1:0] a;
        a = 2'd0;
        if (i >= 0 && i < ROUNDS) begin
            a = SHIFT_SCHED[2*i +: 2];
        end
        return a;
    endfunction

    state_e             state_q, state_d;
    logic [4:0]         l_q, l_d, r_q, r_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mode_q, mode_d;

    logic [KEY_W-1:0]   key_p10;
    logic [4:0]         l_enc0, r_enc0, l_dec0, r_dec0;
    logic [4:0]         l_rot, r_rot;
    logic [1:0]         step_amt;
    logic               last_sub;

    always_comb begin
        key_p10 = p10(key10);
        l_enc0  = rotl5(key_p10[9:5], SHIFT_SCHED[1:0]);
        r_enc0  = rotl5(key_p10[4:0], SHIFT_SCHED[1:0]);
        // A cumulative shift of 4 does not fit a 2-bit amount; left 4 == right 1.
        if (TOTAL_SHIFT == 4) begin
            l_dec0 = rotr5(key_p10[9:5], 2'd1);
            r_dec0 = rotr5(key_p10[4:0], 2'd1);
        end else begin
            l_dec0 = rotl5(key_p10[9:5], 2'(TOTAL_SHIFT));
            r_dec0 = rotl5(key_p10[4:0], 2'(TOTAL_SHIFT));
        end
    end

    // Encrypt applies the next round's shift; decrypt undoes the current one.
    always_comb begin
        step_amt = mode_q ? sched_amt(int'(idx_q)) : sched_amt(int'(idx_q) + 1);
        last_sub = mode_q ? (idx_q == '0) : (idx_q == IDX_W'(ROUNDS - 1));
    end

    sdes_half_rot u_rot_l (
        .din       (l_q),
        .amt       (step_amt),
        .dir_right (mode_q),
        .dout      (l_rot)
    );

    sdes_half_rot u_rot_r (
        .din       (r_q),
        .amt       (step_amt),
        .dir_right (mode_q),
        .dout      (r_rot)
    );

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = decrypt;
                    state_d = EMIT;
                    if (decrypt) begin
                        l_d   = l_dec0;
                        r_d   = r_dec0;
                        idx_d = IDX_W'(ROUNDS - 1);
                    end else begin
                        l_d   = l_enc0;
                        r_d   = r_enc0;
                        idx_d = '0;
                    end
                end
            end
            EMIT: begin
                if (key_ready) begin
                    if (last_sub) begin
                        state_d = DONE;
                    end else begin
                        l_d   = l_rot;
                        r_d   = r_rot;
                        idx_d = mode_q ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            l_q     <= '0;
            r_q     <= '0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        key_valid = (state_q == EMIT);
        done      = (state_q == DONE);
        round_key = key_valid ? p8({l_q, r_q}) : '0;
        round_idx = key_valid ? idx_q : '0;
    end

endmodule

// File: tb/tb_sdes_key_sched.sv
// tb/tb_sdes_key_sched.sv - scoreboard bench for sdes_key_sched (ROUNDS=2 and ROUNDS=4)
module tb_sdes_key_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       start2, dec2, kr2, busy2, kv2, done2;
    logic [9:0] key2;
    logic [7:0] rk2;
    logic [0:0] ri2;

    logic       start4, dec4, kr4, busy4, kv4, done4;
    logic [9:0] key4;
    logic [7:0] rk4;
    logic [1:0] ri4;

    sdes_key_sched #(.ROUNDS(2), .SHIFT_SCHED(4'b10_01)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .key10(key2), .decrypt(dec2),
        .busy(busy2), .key_valid(kv2), .key_ready(kr2), .round_key(rk2),
        .round_idx(ri2), .done(done2)
    );

    sdes_key_sched #(.ROUNDS(4), .SHIFT_SCHED(8'b01_10_10_01)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .key10(key4), .decrypt(dec4),
        .busy(busy4), .key_valid(kv4), .key_ready(kr4), .round_key(rk4),
        .round_idx(ri4), .done(done4)
    );

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        bit         is_done;
        logic [7:0] key;
        int         idx;
    } exp_t;

    exp_t sb2[$];
    exp_t sb4[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string what);
        n_vec++;
        n_miss++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic exp_t mk(input bit d, input logic [7:0] k, input int i);
        exp_t e;
        e.is_done = d;
        e.key     = k;
        e.idx     = i;
        return e;
    endfunction

    // Table-driven reference: P10, cumulative left rotate of both halves, P8.
    function automatic logic [7:0] ref_subkey(input logic [9:0] key, input int s);
        int t10[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
        int t8[8]   = '{6, 3, 7, 4, 8, 5, 10, 9};
        logic [9:0] p;
        logic [4:0] l, r, l2, r2;
        logic [9:0] c;
        logic [7:0] o;
        for (int i = 0; i < 10; i++) p[9-i] = key[10 - t10[i]];
        l = p[9:5];
        r = p[4:0];
        for (int i = 0; i < 5; i++) begin
            l2[(i + s) % 5] = l[i];
            r2[(i + s) % 5] = r[i];
        end
        c = {l2, r2};
        for (int i = 0; i < 8; i++) o[7-i] = c[10 - t8[i]];
        return o;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (kv2 && kr2) begin
                if (sb2.size() == 0) flag("sb2_key", "subkey presented with nothing expected");
                else begin
                    e = sb2.pop_front();
                    if (e.is_done) flag("sb2_key", "subkey presented where done expected");
                    else begin
                        chk("sb2_round_key", rk2, e.key);
                        chk("sb2_round_idx", 32'(ri2), e.idx);
                    end
                end
            end
            if (done2) begin
                if (sb2.size() == 0) flag("sb2_done", "done with nothing expected");
                else begin
                    e = sb2.pop_front();
                    chk("sb2_done_expected", 32'(e.is_done), 32'd1);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (kv4 && kr4) begin
                if (sb4.size() == 0) flag("sb4_key", "subkey presented with nothing expected");
                else begin
                    e = sb4.pop_front();
                    if (e.is_done) flag("sb4_key", "subkey presented where done expected");
                    else begin
                        chk("sb4_round_key", rk4, e.key);
                        chk("sb4_round_idx", 32'(ri4), e.idx);
                    end
                end
            end
            if (done4) begin
                if (sb4.size() == 0) flag("sb4_done", "done with nothing expected");
                else begin
                    e = sb4.pop_front();
                    chk("sb4_done_expected", 32'(e.is_done), 32'd1);
                end
            end
        end
    end

    task automatic do_start(input int sel, input logic [9:0] k, input logic d);
        @(posedge clk);
        #1;
        if (sel == 2) begin start2 = 1'b1; key2 = k; dec2 = d; end
        else          begin start4 = 1'b1; key4 = k; dec4 = d; end
        @(negedge clk);
        chk("latency_pre_valid", (sel == 2) ? kv2 : kv4, 1'b0);
        @(posedge clk);
        #1;
        // Scramble the inputs to show they are not re-sampled.
        if (sel == 2) begin start2 = 1'b0; key2 = ~k; dec2 = ~d; end
        else          begin start4 = 1'b0; key4 = ~k; dec4 = ~d; end
        @(negedge clk);
        chk("latency_valid", (sel == 2) ? kv2 : kv4, 1'b1);
        chk("busy_in_emit", (sel == 2) ? busy2 : busy4, 1'b1);
    endtask

    task automatic wait_done(input int sel);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if ((sel == 2) ? done2 : done4) got = 1'b1;
        end
        if (!got) flag("done_timeout", "no done pulse within 40 cycles");
        else begin
            chk("done_busy", (sel == 2) ? busy2 : busy4, 1'b1);
            @(negedge clk);
            chk("done_one_cycle", (sel == 2) ? done2 : done4, 1'b0);
            chk("idle_after_done", (sel == 2) ? busy2 : busy4, 1'b0);
        end
    endtask

    task automatic push_enc2();
        sb2.push_back(mk(0, 8'b10100100, 0));
        sb2.push_back(mk(0, 8'b01000011, 1));
        sb2.push_back(mk(1, 8'h00, 0));
    endtask

    localparam logic [9:0] KEY_A = 10'b1010000010;
    localparam logic [9:0] KEY_B = 10'b1110001110;

    initial begin
        int         sched4[4] = '{1, 2, 2, 1};
        logic [7:0] ks4[4];
        int         cum;

        rst_n = 1'b0;
        start2 = 0; dec2 = 0; kr2 = 1; key2 = '0;
        start4 = 0; dec4 = 0; kr4 = 1; key4 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy2, 1'b0);
        chk("reset_valid", kv2, 1'b0);
        chk("reset_done", done2, 1'b0);
        chk("reset_round_key", rk2, 8'h00);
        chk("reset_round_idx", 32'(ri2), 32'd0);
        rst_n = 1'b1;

        // Encrypt and decrypt of the classic key.
        push_enc2();
        do_start(2, KEY_A, 1'b0);
        wait_done(2);

        sb2.push_back(mk(0, 8'b01000011, 1));
        sb2.push_back(mk(0, 8'b10100100, 0));
        sb2.push_back(mk(1, 8'h00, 0));
        do_start(2, KEY_A, 1'b1);
        wait_done(2);

        // Backpressure on subkey 0, with an ignored start during EMIT.
        kr2 = 1'b0;
        push_enc2();
        do_start(2, KEY_A, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            start2 = (c == 0);
            key2   = KEY_B;
            dec2   = 1'b1;
            @(negedge clk);
            chk("bp_valid", kv2, 1'b1);
            chk("bp_round_key", rk2, 8'b10100100);
            chk("bp_round_idx", 32'(ri2), 32'd0);
        end
        @(posedge clk);
        #1;
        start2 = 1'b0;
        kr2    = 1'b1;
        wait_done(2);

        // Asynchronous reset in the middle of EMIT.
        kr2 = 1'b0;
        do_start(2, KEY_B, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", kv2, 1'b0);
        chk("arst_busy", busy2, 1'b0);
        chk("arst_round_key", rk2, 8'h00);
        chk("arst_round_idx", 32'(ri2), 32'd0);
        chk("arst_done", done2, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        kr2   = 1'b1;
        push_enc2();
        do_start(2, KEY_A, 1'b0);
        wait_done(2);

        // Four-round schedule against the reference model.
        cum = 0;
        for (int i = 0; i < 4; i++) begin
            cum += sched4[i];
            ks4[i] = ref_subkey(KEY_B, cum % 5);
        end
        for (int i = 0; i < 4; i++) sb4.push_back(mk(0, ks4[i], i));
        sb4.push_back(mk(1, 8'h00, 0));
        do_start(4, KEY_B, 1'b0);
        wait_done(4);

        for (int i = 3; i >= 0; i--) sb4.push_back(mk(0, ks4[i], i));
        sb4.push_back(mk(1, 8'h00, 0));
        do_start(4, KEY_B, 1'b1);
        wait_done(4);

        repeat (2) @(negedge clk);
        chk("sb2_drained", 32'(sb2.size()), 32'd0);
        chk("sb4_drained", 32'(sb4.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
